// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared types and constants for the instruction prefetch queue.
//   INST_NOP  - canonical no-op encoding (addi x0,x0,0)
//   PC_STEP   - byte distance between sequential instructions
//   entry_t   - one queued {pc, inst} pair at the default 32/32 widths
//   fetch_state_t - request channel state
//   cnt_w()   - width of a counter that must hold 0..depth inclusive
package prefetch_pkg;

  localparam logic [31:0] INST_NOP = 32'h00000013;
  localparam int          PC_STEP  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,      // no request on the bus
    S_REQ,       // request valid, PC belongs to the current stream
    S_REQ_STALE  // request valid, issued before a redirect; its response is squashed
  } fetch_state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO of DEPTH entries.
//   i_clk, i_rst   - clock, synchronous active-high reset
//   i_clear        - drop all entries; wins over a same-cycle push or pop
//   i_push, i_data - write one entry (ignored when full and not popping)
//   i_pop          - remove the head (ignored when empty)
//   o_valid/o_data - head entry, read straight from storage
//   o_count        - number of stored entries
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop & (r_cnt != '0);
  assign w_do_push = i_push & ((r_cnt != CW'(DEPTH)) | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_valid = (r_cnt != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: instruction fetch front end with up to DEPTH
// requested-but-unconsumed instructions and a {pc, inst} queue.
//   clk, rst                         - clock, synchronous active-high reset
//   PC, Inst_Req_Valid, Inst_Req_Ack - request channel to instruction memory
//   Instruction, Inst_Valid, Inst_Ack- response channel (always accepted)
//   fetch_valid/inst/pc, fetch_ready - queue head to the core
//   redirect_valid, redirect_pc      - flush and restart at a new address
//   drop_cnt_total                   - count of squashed responses (wraps)
module inst_prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] PC,
  output logic              Inst_Req_Valid,
  input  logic              Inst_Req_Ack,
  input  logic [INST_W-1:0] Instruction,
  input  logic              Inst_Valid,
  output logic              Inst_Ack,
  output logic              fetch_valid,
  output logic [INST_W-1:0] fetch_inst,
  output logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       drop_cnt_total
);

  localparam int CW = cnt_w(DEPTH);

  fetch_state_t      r_state;
  logic              r_req_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_redir_pc;  // target held while a stale request drains
  logic [ADDR_W-1:0] r_tag;       // PC of the next response that will be queued
  logic [CW-1:0]     r_out;
  logic [CW-1:0]     r_squash;
  logic [31:0]       r_drop;

  logic              w_ack_fire;
  logic              w_resp_fire;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_stale_ack;
  logic              w_pending_next;
  logic              w_credit;
  logic              w_fifo_valid;
  logic [CW-1:0]     w_fifo_cnt;
  logic [CW-1:0]     w_out_next;
  logic [CW-1:0]     w_cnt_next;
  logic [CW:0]       w_used_next;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_pc_after;
  logic [ADDR_W+INST_W-1:0] w_head;

  assign w_tgt       = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_ack_fire  = r_req_valid & Inst_Req_Ack;
  // Beats with nothing outstanding are strays (e.g. from before reset).
  assign w_resp_fire = Inst_Valid & (r_out != '0);
  assign w_drop      = w_resp_fire & (r_squash != '0);
  assign w_push      = w_resp_fire & ~w_drop & ~redirect_valid;
  assign w_pop       = w_fifo_valid & fetch_ready & ~redirect_valid;
  assign w_stale_ack = w_ack_fire & (r_state == S_REQ_STALE);
  assign w_pending_next = r_req_valid & ~Inst_Req_Ack;

  assign w_out_next  = r_out + CW'(w_ack_fire) - CW'(w_resp_fire);
  assign w_cnt_next  = redirect_valid ? '0 : w_fifo_cnt + CW'(w_push) - CW'(w_pop);
  // Credit is judged on next-cycle occupancy so the registered request
  // never overcommits the queue.
  assign w_used_next = {1'b0, w_out_next} + {1'b0, w_cnt_next};
  assign w_credit    = (w_used_next < (CW+1)'(DEPTH));

  always_comb begin
    w_pc_after = r_pc;
    if (redirect_valid)   w_pc_after = w_tgt;
    else if (w_stale_ack) w_pc_after = r_redir_pc;
    else if (w_ack_fire)  w_pc_after = r_pc + ADDR_W'(PC_STEP);
  end

  // Request FSM. An unacked request is never withdrawn or moved; a redirect
  // only parks the new target until the old request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_pc        <= RESET_PC;
      r_redir_pc  <= RESET_PC;
    end else if (w_pending_next) begin
      r_req_valid <= 1'b1;
      r_state     <= (redirect_valid || r_state == S_REQ_STALE) ? S_REQ_STALE : S_REQ;
      if (redirect_valid) r_redir_pc <= w_tgt;
    end else begin
      r_pc        <= w_pc_after;
      r_req_valid <= w_credit;
      r_state     <= w_credit ? S_REQ : S_IDLE;
    end
  end

  // Outstanding/squash bookkeeping. On redirect everything still in flight
  // (including this cycle's ack) becomes squashable; a stale request adds
  // itself when it is finally accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_squash <= '0;
      r_tag    <= RESET_PC;
      r_drop   <= '0;
    end else begin
      r_out <= w_out_next;
      if (redirect_valid) r_squash <= w_out_next;
      else                r_squash <= r_squash - CW'(w_drop) + CW'(w_stale_ack);
      if (redirect_valid) r_tag <= w_tgt;
      else if (w_push)    r_tag <= r_tag + ADDR_W'(PC_STEP);
      if (w_drop) r_drop <= r_drop + 32'd1;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + INST_W),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (redirect_valid),
    .i_push  (w_push),
    .i_data  ({r_tag, Instruction}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .o_count (w_fifo_cnt)
  );

  assign PC             = r_pc;
  assign Inst_Req_Valid = r_req_valid;
  assign Inst_Ack       = ~rst;
  assign fetch_valid    = w_fifo_valid;
  assign fetch_pc       = w_head[ADDR_W+INST_W-1:INST_W];
  assign fetch_inst     = w_head[INST_W-1:0];
  assign drop_cnt_total = r_drop;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;
  import prefetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ack = 1'b0;
  logic [31:0] Instruction = '0;
  logic        Inst_Valid = 1'b0;
  logic        Inst_Ack;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] drop_cnt_total;

  inst_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ack(Inst_Req_Ack), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
    .Inst_Ack(Inst_Ack), .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
    .fetch_pc(fetch_pc), .fetch_ready(fetch_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .drop_cnt_total(drop_cnt_total)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ack_cnt = 0;
  int pop_cnt = 0;

  // Reference model: every accepted request carries the stream epoch it was
  // raised in; a redirect opens a new epoch and any response from an older
  // epoch is a squash.
  typedef struct { logic [31:0] pc; int ep; } req_t;
  req_t        oq[$];   // accepted, awaiting response
  entry_t      fq[$];   // expected queue contents
  logic [31:0] mq[$];   // memory side: addresses seen on the bus
  logic [31:0] nxt_pc;
  int          epoch;
  bit          held;
  req_t        cur;
  int          drops;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
  endfunction

  task automatic model_clear();
    oq.delete(); fq.delete(); mq.delete();
    nxt_pc = RESET_PC; epoch = 0; held = 0; drops = 0;
    cur.pc = RESET_PC; cur.ep = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; Inst_Req_Ack = 0; Inst_Valid = 0; fetch_ready = 0; redirect_valid = 0;
    repeat (n) @(posedge clk);
    #1;
    checks++; if (PC !== RESET_PC) begin errors++; $display("FAIL rst_pc got=%h exp=%h", PC, RESET_PC); end
    checks++; if (Inst_Req_Valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", Inst_Req_Valid); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fetch_valid got=%b exp=0", fetch_valid); end
    checks++; if (drop_cnt_total !== 32'd0) begin errors++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt_total); end
    checks++; if (Inst_Ack !== 1'b0) begin errors++; $display("FAIL rst_inst_ack got=%b exp=0", Inst_Ack); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One scenario driver; probabilities are percentages. Every cycle the DUT
  // is compared with the model before the model steps past the clock edge.
  task automatic run_traffic(input int n, input int p_ack, input int p_resp, input int p_ready,
                             input int p_redir, input logic [31:0] rpc, input bit rnd_pc);
    int used; bit exp_req, resp, ack, pop; req_t r; entry_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      Inst_Req_Ack   = ($urandom_range(99) < p_ack);
      fetch_ready    = ($urandom_range(99) < p_ready);
      redirect_valid = ($urandom_range(99) < p_redir);
      redirect_pc    = rnd_pc ? ($urandom & 32'h0000_fffff) : rpc;
      if (mq.size() > 0) begin
        Inst_Valid  = ($urandom_range(99) < p_resp);
        Instruction = mem_data(mq[0]);
      end else begin
        Inst_Valid  = ($urandom_range(99) < 5);
        Instruction = INST_NOP;
      end
      #1;
      used    = oq.size() + fq.size();
      exp_req = held || (used < DEPTH);
      checks++;
      if (Inst_Req_Valid !== exp_req) begin
        errors++; $display("FAIL req_valid cyc=%0d got=%b exp=%b used=%0d", cyc, Inst_Req_Valid, exp_req, used);
      end
      if (exp_req) begin
        if (!held) begin cur.pc = nxt_pc; cur.ep = epoch; end
        checks++;
        if (PC !== cur.pc) begin errors++; $display("FAIL req_pc cyc=%0d got=%h exp=%h", cyc, PC, cur.pc); end
      end
      checks++;
      if (fetch_valid !== (fq.size() != 0)) begin
        errors++; $display("FAIL fetch_valid cyc=%0d got=%b exp=%b", cyc, fetch_valid, fq.size() != 0);
      end else if (fq.size() != 0) begin
        checks++;
        if (fetch_pc !== fq[0].pc || fetch_inst !== fq[0].inst) begin
          errors++; $display("FAIL head cyc=%0d got=%h/%h exp=%h/%h", cyc, fetch_pc, fetch_inst, fq[0].pc, fq[0].inst);
        end
      end
      checks++;
      if (drop_cnt_total !== 32'(drops)) begin errors++; $display("FAIL drop_cnt cyc=%0d got=%0d exp=%0d", cyc, drop_cnt_total, drops); end
      checks++;
      if (Inst_Ack !== 1'b1) begin errors++; $display("FAIL inst_ack cyc=%0d got=%b exp=1", cyc, Inst_Ack); end
      // advance the model across the coming edge
      resp = Inst_Valid && (oq.size() > 0);
      ack  = exp_req && Inst_Req_Ack;
      pop  = (fq.size() > 0) && fetch_ready;
      if (resp) begin
        r = oq.pop_front();
        void'(mq.pop_front());
        if (r.ep != epoch) drops++;
        else if (!redirect_valid) begin e.pc = r.pc; e.inst = mem_data(r.pc); fq.push_back(e); end
      end
      if (pop && !redirect_valid) begin void'(fq.pop_front()); pop_cnt++; end
      if (ack) begin
        oq.push_back(cur); mq.push_back(PC); ack_cnt++;
        if (cur.ep == epoch) nxt_pc = cur.pc + 32'd4;
      end
      held = exp_req && !ack;
      if (redirect_valid) begin fq.delete(); epoch++; nxt_pc = redirect_pc & ~32'd3; end
    end
  endtask

  task automatic test_reset();
    do_reset(3);
  endtask

  task automatic test_stream();
    do_reset(2);
    pop_cnt = 0;
    run_traffic(40, 100, 100, 100, 0, 0, 0);
    checks++;
    if (pop_cnt < 36) begin errors++; $display("FAIL stream_rate got=%0d exp>=36", pop_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset(2);
    ack_cnt = 0;
    run_traffic(12, 100, 100, 0, 0, 0, 0);
    checks++;
    if (ack_cnt != 4) begin errors++; $display("FAIL bp_acks got=%0d exp=4", ack_cnt); end
    checks++;
    if (Inst_Req_Valid !== 1'b0) begin errors++; $display("FAIL bp_idle got=%b exp=0", Inst_Req_Valid); end
    run_traffic(1, 100, 100, 100, 0, 0, 0);
    run_traffic(4, 100, 100, 0, 0, 0, 0);
    checks++;
    if (ack_cnt != 5) begin errors++; $display("FAIL bp_refill got=%0d exp=5", ack_cnt); end
  endtask

  task automatic test_redirect_squash();
    do_reset(2);
    pop_cnt = 0;
    run_traffic(3, 100, 0, 100, 0, 0, 0);
    run_traffic(1, 100, 0, 100, 100, 32'h100, 0);
    run_traffic(14, 100, 100, 100, 0, 0, 0);
    checks++;
    if (drop_cnt_total !== 32'd4) begin errors++; $display("FAIL squash_drops got=%0d exp=4", drop_cnt_total); end
    checks++;
    if (pop_cnt < 5) begin errors++; $display("FAIL squash_resume got=%0d exp>=5", pop_cnt); end
  endtask

  task automatic test_stale_redirect();
    do_reset(2);
    run_traffic(2, 100, 100, 100, 0, 0, 0);
    run_traffic(1, 0, 100, 100, 100, 32'h203, 0);
    run_traffic(5, 0, 100, 100, 0, 0, 0);
    run_traffic(12, 100, 100, 100, 0, 0, 0);
    checks++;
    if (drop_cnt_total !== 32'd1) begin errors++; $display("FAIL stale_drops got=%0d exp=1", drop_cnt_total); end
  endtask

  task automatic test_same_cycle();
    do_reset(2);
    run_traffic(4, 100, 100, 100, 0, 0, 0);
    run_traffic(1, 100, 100, 100, 100, 32'h300, 0);
    @(posedge clk); #1;
    checks++;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL same_cycle_flush got=%b exp=0", fetch_valid); end
    run_traffic(15, 100, 100, 100, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    run_traffic(6, 100, 30, 0, 0, 0, 0);
    run_traffic(4, 40, 60, 50, 100, 0, 1);
    run_traffic(25, 100, 100, 100, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    run_traffic(3, 100, 100, 0, 0, 0, 0);
    run_traffic(2, 100, 0, 0, 0, 0, 0);
    do_reset(1);
    run_traffic(10, 100, 100, 100, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset(2);
    for (int ph = 0; ph < 30; ph++)
      run_traffic(100, $urandom_range(100), $urandom_range(100), $urandom_range(100),
                  $urandom_range(8), 0, 1);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_squash();
    test_stale_redirect();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
